cp0_exc_ctrl: RTL and testbench

Exception/interrupt controller at the commit end of the exception path; consumes the 5-bit codes produced by the per-stage exception detectors (IF address check, decode, ALU, memory).
- Holds the CP0 registers SR(12), Cause(13), EPC(14) and PRId(15).
- Arbitrates hardware interrupts against synchronous exceptions, decides whether to take the exception, and redirects fetch to the handler.
- Sequences the handler enter/return states on ERET.

---
 rtl/cp0_pkg.sv | 33 +++
 rtl/exc_prio_arb.sv | 26 ++
 rtl/cp0_exc_ctrl.sv | 118 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions,
// and the default handler/PRId values used by the exception controller.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'b11111;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int unsigned SR_IE        = 0;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_BD     = 31;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam logic [31:0] PRID_DEF         = 32'h2017_1227;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exc_prio_arb.sv
// Combinational arbitration between hardware interrupts and the synchronous
// exception of the committing instruction; interrupts take priority.
module exc_prio_arb
  import cp0_pkg::*;
#(
  parameter logic [4:0] NEXC = EXC_NONE
) (
  input  logic [5:0] ip,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_m,
  output logic       take_exc,
  output logic       int_req,
  output logic [4:0] exc_code_sel
);

  logic exc_req;

  assign int_req      = ie & ~exl & (|(ip & im));
  assign exc_req      = ~exl & (exc_code_m != NEXC);
  assign take_exc     = int_req | exc_req;
  // A pending interrupt discards the instruction's own code; it re-raises on return.
  assign exc_code_sel = int_req ? EXC_INT : exc_code_m;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR/Cause/EPC/PRId registers, handler
// entry on exception or interrupt, and return on ERET.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [31:0] PRID_VAL     = PRID_DEF,
  parameter logic [4:0]  NEXC         = EXC_NONE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exc_code_m,
  input  logic        bd_m,
  input  logic        eret_m,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        take_exc,
  output logic [31:0] handler_pc,
  output logic [31:0] eret_pc,
  output logic        exl
);

  exc_state_e  state_q;
  logic [5:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [5:0]  ip_q;
  logic        bd_q;
  logic [4:0]  exccode_q;
  logic [31:0] epc_q;

  logic        int_req;
  logic [4:0]  exc_code_sel;
  logic        eret_ok;
  logic        sr_we;
  logic        epc_we;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;
  logic        unused_wdata;

  exc_prio_arb #(.NEXC(NEXC)) u_arb (
    .ip           (ip_q),
    .im           (im_q),
    .ie           (ie_q),
    .exl          (exl_q),
    .exc_code_m   (exc_code_m),
    .take_exc     (take_exc),
    .int_req      (int_req),
    .exc_code_sel (exc_code_sel)
  );

  assign eret_ok = eret_m & (exc_code_m == NEXC);
  // An exception in the same cycle squashes the MTC0.
  assign sr_we   = cp0_we & ~take_exc & (cp0_addr == CP0_SR);
  assign epc_we  = cp0_we & ~take_exc & (cp0_addr == CP0_EPC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      ip_q      <= '0;
      bd_q      <= 1'b0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      ip_q <= hwint;
      if (take_exc) begin
        state_q   <= ST_HANDLER;
        exl_q     <= 1'b1;
        exccode_q <= exc_code_sel;
        bd_q      <= bd_m;
        epc_q     <= bd_m ? (pc_m - 32'd4) : pc_m;
      end else begin
        if (epc_we) begin
          epc_q <= cp0_wdata;
        end
        // MTC0 to SR lands first; a concurrent ERET then clears EXL on top of it.
        if (eret_ok) begin
          state_q <= ST_RUN;
          exl_q   <= 1'b0;
        end else if (sr_we) begin
          state_q <= cp0_wdata[SR_EXL] ? ST_HANDLER : ST_RUN;
          exl_q   <= cp0_wdata[SR_EXL];
        end
        if (sr_we) begin
          im_q <= cp0_wdata[SR_IM_HI:SR_IM_LO];
          ie_q <= cp0_wdata[SR_IE];
        end
      end
    end
  end

  assign sr_rd    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_rd = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = sr_rd;
      CP0_CAUSE: cp0_rdata = cause_rd;
      CP0_EPC:   cp0_rdata = epc_q;
      CP0_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = '0;
    endcase
  end

  assign handler_pc   = HANDLER_ADDR;
  assign eret_pc      = epc_q;
  assign exl          = exl_q;
  assign unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2], state_q};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expected values.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic [4:0]  exc_code_m;
  logic        bd_m;
  logic        eret_m;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        take_exc;
  logic [31:0] handler_pc;
  logic [31:0] eret_pc;
  logic        exl;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc_m       (pc_m),
    .exc_code_m (exc_code_m),
    .bd_m       (bd_m),
    .eret_m     (eret_m),
    .hwint      (hwint),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .take_exc   (take_exc),
    .handler_pc (handler_pc),
    .eret_pc    (eret_pc),
    .exl        (exl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic idle();
    pc_m = 32'h0; exc_code_m = 5'b11111; bd_m = 1'b0; eret_m = 1'b0;
    cp0_we = 1'b0; cp0_wdata = 32'h0;
  endtask

  initial begin
    idle();
    hwint = 6'b0; cp0_addr = 5'd0; reset = 1'b0;
    #12;
    reset = 1'b1;
    step();
    chk("rst_exl", {31'b0, exl}, 32'h0);
    chk("rst_take", {31'b0, take_exc}, 32'h0);
    chk("rst_hpc", handler_pc, 32'h0000_4180);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);

    // AdEL from IF
    pc_m = 32'h0000_2ffc; exc_code_m = 5'd4; #1;
    chk("adel_take", {31'b0, take_exc}, 32'h1);
    chk("adel_hpc", handler_pc, 32'h0000_4180);
    step(); idle();
    rd("adel_epc", 5'd14, 32'h0000_2ffc);
    rd("adel_cause", 5'd13, 32'h0000_0010);
    chk("adel_exl", {31'b0, exl}, 32'h1);

    // masked while in handler
    pc_m = 32'h0000_5000; exc_code_m = 5'd10; #1;
    chk("mask_take", {31'b0, take_exc}, 32'h0);
    step(); idle();
    rd("mask_cause", 5'd13, 32'h0000_0010);
    rd("mask_epc", 5'd14, 32'h0000_2ffc);
    eret_m = 1'b1; #1;
    chk("eret_pc", eret_pc, 32'h0000_2ffc);
    chk("eret_exl_same", {31'b0, exl}, 32'h1);
    step(); idle(); #1;
    chk("eret_exl_next", {31'b0, exl}, 32'h0);

    // delay-slot overflow
    pc_m = 32'h0000_3010; exc_code_m = 5'd12; bd_m = 1'b1; #1;
    chk("ov_take", {31'b0, take_exc}, 32'h1);
    step(); idle();
    rd("ov_epc", 5'd14, 32'h0000_300c);
    rd("ov_cause", 5'd13, 32'h8000_0030);
    eret_m = 1'b1; step(); idle();

    // interrupt priority
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; hwint = 6'b000001; #1;
    chk("raw_old", cp0_rdata, 32'h0);
    chk("int_take_early", {31'b0, take_exc}, 32'h0);
    step(); idle();
    rd("raw_new", 5'd12, 32'h0000_0401);
    pc_m = 32'h0000_6000; exc_code_m = 5'd4; #1;
    chk("int_take", {31'b0, take_exc}, 32'h1);
    step(); idle();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_epc", 5'd14, 32'h0000_6000);
    rd("int_sr", 5'd12, 32'h0000_0403);
    hwint = 6'b0; step();
    eret_m = 1'b1; step(); idle();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0; step(); idle();

    // exception suppresses concurrent MTC0 EPC
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3400;
    pc_m = 32'h0000_3008; exc_code_m = 5'd5; #1;
    chk("mtc_take", {31'b0, take_exc}, 32'h1);
    step(); idle();
    rd("mtc_epc", 5'd14, 32'h0000_3008);
    rd("mtc_cause", 5'd13, 32'h0000_0014);

    // MTC0 SR with ERET: write lands, EXL cleared
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403; eret_m = 1'b1;
    step(); idle();
    rd("sr_eret", 5'd12, 32'h0000_0401);
    chk("sr_eret_exl", {31'b0, exl}, 32'h0);

    // ERET with exception in RUN: exception wins
    pc_m = 32'h0000_7000; exc_code_m = 5'd10; eret_m = 1'b1; #1;
    chk("eret_exc_take", {31'b0, take_exc}, 32'h1);
    step(); idle();
    chk("eret_exc_exl", {31'b0, exl}, 32'h1);
    rd("eret_exc_cause", 5'd13, 32'h0000_0028);
    rd("eret_exc_epc", 5'd14, 32'h0000_7000);

    // read-only and unimplemented registers
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hffff_ffff; step(); idle();
    rd("cause_ro", 5'd13, 32'h0000_0028);
    rd("prid", 5'd15, 32'h2017_1227);
    rd("unimpl", 5'd3, 32'h0);

    // async reset mid-handler with a pending eret
    eret_m = 1'b1; #2;
    reset = 1'b0; #1;
    chk("arst_exl", {31'b0, exl}, 32'h0);
    chk("arst_take", {31'b0, take_exc}, 32'h0);
    rd("arst_sr", 5'd12, 32'h0);
    rd("arst_cause", 5'd13, 32'h0);
    rd("arst_epc", 5'd14, 32'h0);
    rd("arst_prid", 5'd15, 32'h2017_1227);
    idle(); step();
    reset = 1'b1; step();

    // EPC wraps for a delay-slot instruction at address 0
    pc_m = 32'h0; exc_code_m = 5'd12; bd_m = 1'b1; step(); idle();
    rd("wrap_epc", 5'd14, 32'hffff_fffc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
